// File: rtl/odo_pkg.sv
// Shared types and default parameters for the odometer readout controller.
package odo_pkg;

  localparam int ODO_W = 32;

  typedef logic [ODO_W-1:0] odo_count_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_COMPARE,
    ST_CLEAR,
    ST_RESP
  } odo_ctrl_state_e;

  localparam int N_ODO_DEF      = 4;
  localparam int CLR_CYCLES_DEF = 2;
  localparam int MAX_TRIES_DEF  = 4;
  localparam int ADDR_W_DEF     = 4;

endpackage

// File: rtl/odo_readout_ctrl_if.sv
// Host-side request/response handshake bundle for odo_readout_ctrl.
// master = host front end, slave = readout controller.
interface odo_readout_ctrl_if #(
  parameter int ADDR_W = odo_pkg::ADDR_W_DEF
);
  import odo_pkg::*;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  odo_count_t        rsp_data;
  logic              rsp_err;
  logic              rsp_unstable;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_unstable
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_unstable
  );

endinterface

// File: rtl/odo_stable_sampler.sv
// Two-flop synchronizer for all odometer count buses plus a channel mux.
// The buses are multi-bit and asynchronous, so a single synchronized word
// may be torn; the controller compares successive samples to find a
// coherent value. Unselected/out-of-range selects read as zero.
module odo_stable_sampler
  import odo_pkg::*;
#(
  parameter int N_ODO  = N_ODO_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_ODO-1:0][ODO_W-1:0] odo_distance,
  input  logic [ADDR_W-1:0]           sel,
  output odo_count_t                  sync_sel
);

  logic [N_ODO-1:0][ODO_W-1:0] meta_q, meta_d;
  logic [N_ODO-1:0][ODO_W-1:0] sync_q, sync_d;

  // next values of the synchronizer chain
  always_comb begin
    meta_d = odo_distance;
    sync_d = meta_q;
  end

  // synchronizer flops for every bit of every channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  // select the addressed channel
  always_comb begin
    sync_sel = '0;
    for (int i = 0; i < N_ODO; i++) begin
      if (sel == ADDR_W'(i)) sync_sel = sync_q[i];
    end
  end

endmodule

// File: rtl/odo_readout_ctrl.sv
// Odometer readout controller: accepts one read at a time, captures a
// coherent count from an asynchronous odometer bus by double sampling,
// then either clears that odometer (clear-on-read) or, with ODO_DELTA_EN
// defined, reports the difference to the previous read of that channel.
// Optional feature macro: ODO_DELTA_EN.
module odo_readout_ctrl
  import odo_pkg::*;
#(
  parameter int N_ODO      = N_ODO_DEF,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF,
  parameter int MAX_TRIES  = MAX_TRIES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  odo_readout_ctrl_if.slave           bus,
  input  logic [N_ODO-1:0][ODO_W-1:0] odo_distance,
  output logic [N_ODO-1:0]            odo_clear
);

  localparam int                TRY_W       = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0]  MAX_TRIES_L = TRY_W'(MAX_TRIES);
  // one extra bit so N_ODO = 2^ADDR_W still compares correctly
  localparam logic [ADDR_W:0]   N_ODO_L     = (ADDR_W + 1)'(N_ODO);
`ifndef ODO_DELTA_EN
  localparam int                CLR_W       = $clog2(CLR_CYCLES + 1);
  localparam logic [CLR_W-1:0]  CLR_LAST    = CLR_W'(CLR_CYCLES - 1);
`endif

  odo_ctrl_state_e   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  odo_count_t        snap_q, snap_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic              unstable_q, unstable_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  odo_count_t        rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_unstable_q, rsp_unstable_d;
  logic [N_ODO-1:0]  odo_clear_q, odo_clear_d;

  odo_count_t        sync_sel;
  logic              addr_ok;
  logic              capture;
  odo_count_t        capture_val;

`ifdef ODO_DELTA_EN
  logic [N_ODO-1:0][ODO_W-1:0] prev_q, prev_d;
  odo_count_t                  prev_sel;
`else
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [N_ODO-1:0]  addr_onehot;
`endif

  odo_stable_sampler #(
    .N_ODO  (N_ODO),
    .ADDR_W (ADDR_W)
  ) u_sampler (
    .clk          (clk),
    .reset_n      (reset_n),
    .odo_distance (odo_distance),
    .sel          (addr_q),
    .sync_sel     (sync_sel)
  );

  assign addr_ok = ({1'b0, addr_q} < N_ODO_L);

`ifdef ODO_DELTA_EN
  // previous reported count of the addressed channel
  always_comb begin
    prev_sel = '0;
    for (int i = 0; i < N_ODO; i++) begin
      if (addr_q == ADDR_W'(i)) prev_sel = prev_q[i];
    end
  end
`else
  // clear strobe pattern for the addressed channel
  always_comb begin
    addr_onehot = '0;
    for (int i = 0; i < N_ODO; i++) begin
      addr_onehot[i] = (addr_q == ADDR_W'(i));
    end
  end
`endif

  // FSM next state and registered-output next values
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    snap_d         = snap_q;
    tries_d        = tries_q;
    unstable_d     = unstable_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    rsp_unstable_d = rsp_unstable_q;
    odo_clear_d    = '0;
    capture        = 1'b0;
    capture_val    = snap_q;
`ifdef ODO_DELTA_EN
    prev_d         = prev_q;
`else
    clr_cnt_d      = clr_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d     = bus.req_addr;
          tries_d    = '0;
          unstable_d = 1'b0;
          state_d    = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (!addr_ok) begin
          rsp_valid_d    = 1'b1;
          rsp_err_d      = 1'b1;
          rsp_data_d     = '0;
          rsp_unstable_d = 1'b0;
          state_d        = ST_RESP;
        end else begin
          snap_d  = sync_sel;
          tries_d = tries_q + TRY_W'(1);
          state_d = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        if (sync_sel == snap_q) begin
          capture     = 1'b1;
          capture_val = snap_q;
        end else if (tries_q < MAX_TRIES_L) begin
          state_d = ST_SAMPLE;
        end else begin
          // out of retries: take the newest sample and flag it
          snap_d      = sync_sel;
          unstable_d  = 1'b1;
          capture     = 1'b1;
          capture_val = sync_sel;
        end

        if (capture) begin
`ifdef ODO_DELTA_EN
          rsp_valid_d    = 1'b1;
          rsp_err_d      = 1'b0;
          rsp_unstable_d = unstable_d;
          rsp_data_d     = capture_val - prev_sel;
          for (int i = 0; i < N_ODO; i++) begin
            if (addr_q == ADDR_W'(i)) prev_d[i] = capture_val;
          end
          state_d        = ST_RESP;
`else
          clr_cnt_d   = '0;
          odo_clear_d = addr_onehot;
          state_d     = ST_CLEAR;
`endif
        end
      end

`ifndef ODO_DELTA_EN
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          rsp_valid_d    = 1'b1;
          rsp_err_d      = 1'b0;
          rsp_unstable_d = unstable_q;
          rsp_data_d     = snap_q;
          state_d        = ST_RESP;
        end else begin
          clr_cnt_d   = clr_cnt_q + CLR_W'(1);
          odo_clear_d = addr_onehot;
        end
      end
`endif

      ST_RESP: begin
        // response fields hold until taken; only valid drops
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // state and output registers; odometers are held clear during reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      snap_q         <= '0;
      tries_q        <= '0;
      unstable_q     <= 1'b0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      rsp_unstable_q <= 1'b0;
      odo_clear_q    <= '1;
`ifdef ODO_DELTA_EN
      prev_q         <= '0;
`else
      clr_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      snap_q         <= snap_d;
      tries_q        <= tries_d;
      unstable_q     <= unstable_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      rsp_unstable_q <= rsp_unstable_d;
      odo_clear_q    <= odo_clear_d;
`ifdef ODO_DELTA_EN
      prev_q         <= prev_d;
`else
      clr_cnt_q      <= clr_cnt_d;
`endif
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_unstable = rsp_unstable_q;
  assign odo_clear        = odo_clear_q;

endmodule

// File: tb/tb_odo_readout_ctrl.sv
// Self-checking bench for odo_readout_ctrl (default or ODO_DELTA_EN build).
module tb_odo_readout_ctrl;
  import odo_pkg::*;

  localparam int N_ODO      = 4;
  localparam int CLR_CYCLES = 2;
  localparam int MAX_TRIES  = 4;
  localparam int ADDR_W     = 4;
`ifdef ODO_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif
  localparam int LAT_BASE = DELTA ? 2 : 2 + CLR_CYCLES;

  logic clk = 1'b0;
  logic reset_n;
  logic [N_ODO-1:0][ODO_W-1:0] odo_distance;
  logic [N_ODO-1:0]            odo_clear;

  odo_readout_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  odo_readout_ctrl #(
    .N_ODO      (N_ODO),
    .CLR_CYCLES (CLR_CYCLES),
    .MAX_TRIES  (MAX_TRIES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .odo_distance (odo_distance),
    .odo_clear    (odo_clear)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [31:0] prev [N_ODO];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_val(input int c, input logic [31:0] v);
    odo_distance[c] = v;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // mode 0: count static; mode 1: count steps to nv on the request cycle
  // then holds (one retry); mode 2: channel 0 increments every cycle.
  task automatic do_read(input int a, input int mode, input logic [31:0] nv,
                         input int bp, input string tag);
    int lat, hits, bad, stall_bad, exp_lat;
    bit err, unst;
    logic [31:0] raw, exp_d;
    logic [N_ODO-1:0] mask;
    lat = 0; hits = 0; bad = 0; stall_bad = 0;
    err  = (a >= N_ODO);
    unst = (mode == 2);
    raw  = '0;
    exp_lat = LAT_BASE;
    if (mode == 1) begin
      raw = nv;
      exp_lat = LAT_BASE + 2;
    end else if (mode == 2) begin
      // final compare uses the bus value 2*MAX_TRIES-2 edges after acceptance
      raw = odo_distance[0] + 32'(2 * MAX_TRIES - 1);
      exp_lat = LAT_BASE + 2 * (MAX_TRIES - 1);
    end else if (!err) begin
      raw = odo_distance[a];
    end
    mask  = '0;
    exp_d = '0;
    if (err) begin
      exp_lat = 1;
    end else begin
      exp_d   = DELTA ? raw - prev[a] : raw;
      prev[a] = raw;
      mask    = DELTA ? '0 : (N_ODO'(1) << a);
    end

    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = ADDR_W'(a);
    if (mode == 1) odo_distance[a] = nv;
    else if (mode == 2) odo_distance[0] = odo_distance[0] + 32'd1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = ADDR_W'($urandom);
    chk({tag, ".busy"}, 32'(bus.req_ready), 32'd0);

    while (!bus.rsp_valid && lat < 40) begin
      if (mask != '0 && odo_clear == mask) hits++;
      else if (odo_clear != '0) bad++;
      if (mode == 2) odo_distance[0] = odo_distance[0] + 32'd1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));

    if (bus.rsp_valid) begin
      chk({tag, ".data"}, bus.rsp_data, exp_d);
      chk({tag, ".err"}, 32'(bus.rsp_err), 32'(err));
      chk({tag, ".unstable"}, 32'(bus.rsp_unstable), 32'(unst));
      chk({tag, ".clr_cycles"}, 32'(hits), (mask != '0) ? 32'(CLR_CYCLES) : 32'd0);
      chk({tag, ".clr_stray"}, 32'(bad), 32'd0);
      for (int i = 0; i < bp; i++) begin
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = ADDR_W'($urandom);
        @(posedge clk); #1;
        if (!bus.rsp_valid || bus.rsp_data !== exp_d || bus.rsp_err !== err ||
            bus.req_ready || odo_clear != '0) stall_bad++;
      end
      chk({tag, ".stall"}, 32'(stall_bad), 32'd0);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      chk({tag, ".rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, ".rsp_idle"}, 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int a, mode, bp;
    logic [31:0] nv;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N_ODO; i++) begin
      odo_distance[i] = $urandom;
      prev[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_data", bus.rsp_data, 32'd0);
    chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst.rsp_unstable", 32'(bus.rsp_unstable), 32'd0);
    chk("rst.odo_clear", 32'(odo_clear), 32'hF);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.odo_clear", 32'(odo_clear), 32'd0);
    chk("rel.req_ready", 32'(bus.req_ready), 32'd1);

    // directed cases
    set_val(2, 32'h0000_0123);
    do_read(2, 0, '0, 0, "static");
    do_read(7, 0, '0, 0, "badaddr");
    set_val(1, 32'd100);
    do_read(1, 0, '0, 0, "seq100");
    set_val(1, 32'd250);
    do_read(1, 0, '0, 0, "seq250");
    set_val(1, 32'hFFFF_FFF0);
    do_read(1, 0, '0, 0, "wrap_hi");
    set_val(1, 32'h0000_0010);
    do_read(1, 0, '0, 0, "wrap_lo");
    do_read(0, 2, '0, 0, "unstable");
    do_read(1, 1, odo_distance[1] ^ 32'h0000_5A5A, 0, "retry");
    do_read(2, 0, '0, 10, "backpressure");

    // randomized reads against the model
    for (int k = 0; k < 16; k++) begin
      a    = $urandom_range(0, 9);
      mode = (a < N_ODO) ? $urandom_range(0, 1) : 0;
      bp   = $urandom_range(0, 3);
      nv   = '0;
      if (a < N_ODO) begin
        set_val(a, $urandom);
        nv = odo_distance[a] ^ ($urandom | 32'd1);
      end
      do_read(a, mode, nv, bp, "rand");
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    // reset in the middle of a read
    set_val(3, 32'hCAFE_0003);
    bus.req_valid = 1'b1;
    bus.req_addr  = ADDR_W'(3);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (DELTA ? 1 : 2) @(posedge clk);
    #1;
    chk("rstmid.clear_pre", 32'(odo_clear), DELTA ? 32'd0 : 32'h8);
    reset_n = 1'b0;
    #1;
    chk("rstmid.odo_clear", 32'(odo_clear), 32'hF);
    chk("rstmid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstmid.req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < N_ODO; i++) prev[i] = '0;
    @(posedge clk); #1;
    chk("rstmid.rel_clear", 32'(odo_clear), 32'd0);
    chk("rstmid.rel_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid.no_rsp", 32'(bus.rsp_valid), 32'd0);
    do_read(3, 0, '0, 1, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/odo_readout_ctrl.md
# odo_readout_ctrl

Readout controller for the wheel odometer counters. It accepts read requests from the host-interface side over a valid/ready handshake, selects one of N_ODO odometer count buses, and captures a coherent value from counters that run on encoder edges asynchronously to `clk`. It then returns the value and resets that odometer so each read yields the distance travelled since the previous read. It sits between the SPI/register front end and the bank of odometer instances.

## Interface
- N_ODO, 4, number of odometer channels (1..16)
- CLR_CYCLES, 2, clk cycles `odo_clear[i]` is held high per read (≥1)
- MAX_TRIES, 4, sample attempts before accepting an unstable capture (≥1)
- ADDR_W, 4, request address width (2^ADDR_W ≥ N_ODO)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  read request
- req_addr  in  ADDR_W  odometer index
- req_ready  out  1  controller can accept a request
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_data  out  32  distance count (two's complement, signed edge count)
- rsp_err  out  1  address ≥ N_ODO
- rsp_unstable  out  1  MAX_TRIES exhausted without two matching samples
- odo_distance  in  N_ODO×32  packed count buses, channel i at [32i+31:32i], asynchronous to clk
- odo_clear  out  N_ODO  active-high asynchronous clear to each odometer

## Operation
- All `odo_distance` bits pass through a 2-flop synchronizer (`sync_q`) before any use.
- FSM states: IDLE, SAMPLE, COMPARE, CLEAR, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch the address and go to SAMPLE. If the address is out of range, go directly to RESP with `rsp_err`=1 and `rsp_data`=0. No odometer is cleared.
- SAMPLE: `snap <= sync_q[addr]`; increment the try counter. Go to COMPARE.
- COMPARE:
  - If `sync_q[addr] == snap`, go to CLEAR.
  - Otherwise, if tries < MAX_TRIES, go back to SAMPLE.
  - Otherwise, `snap <= sync_q[addr]`, set the unstable flag, and go to CLEAR.
- CLEAR: `odo_clear[addr]`=1 for exactly CLR_CYCLES cycles, then go to RESP. Edges arriving between capture and clear are lost; this is accepted.
- RESP: `rsp_valid`=1 with `rsp_data`=`snap`. All response outputs are held stable until `rsp_ready`. On the handshake, return to IDLE; this handshake cycle is not a request-accept cycle.
- Only one request is in flight at a time. There is no queueing.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `rsp_unstable`=0.
  - `odo_clear` = all ones while `reset_n` is low, so every odometer clears with the system.
  - State is IDLE.
- First edge after reset release: `odo_clear` → 0 and `req_ready` → 1.
- Stable path: `rsp_valid` rises 2+CLR_CYCLES edges after the accepting edge (4 with defaults). Each retry adds 2 cycles.
- Out-of-range address: `rsp_valid` rises 1 edge after acceptance.
- `req_ready` is 0 from the accepting edge until the response handshake completes.
- `reset_n` asserted mid-operation: the FSM aborts immediately and all outputs take their reset values. No response is produced.
- Comparison uses the full 32 bits. Wrap-around of the counter is transparent; no saturation.

## Configuration
- `ODO_DELTA_EN` defined:
  - The CLEAR state is removed, and `odo_clear` is 0 after the reset pulse.
  - A per-channel `prev[N_ODO]` register (reset 0) is kept.
  - `rsp_data` = `snap - prev[addr]` mod 2^32, and `prev[addr] <= snap` on entry to RESP.
  - No edges are lost. Stable-path latency is 2 edges.
- `ODO_DELTA_EN` undefined: clear-on-read behaviour as described above.

## Structure
- Package `odo_pkg`: `ODO_W`=32, `odo_count_t` (logic [31:0]), the `odo_ctrl_state_e` enum, and default parameter constants.
- Sub-module `odo_stable_sampler`:
  - Contains the 2-flop synchronizer of the packed buses plus the per-channel mux.
  - Outputs `sync_q[addr]`.
  - The controller instantiates it once.

## Test plan
- Static count: channel 2 held at 0x0000_0123, request addr 2 → `rsp_valid` at edge 4, `rsp_data`=0x123, `rsp_err`=0, `rsp_unstable`=0, `odo_clear`=4'b0100 for 2 cycles.
- Bad address: request addr 7 with N_ODO=4 → `rsp_valid` at edge 1, `rsp_err`=1, `rsp_data`=0, `odo_clear` stays 0.
- Changing count:
  - Channel 0 increments every cycle → 4 tries exhausted, `rsp_unstable`=1, `rsp_data` equals the last sampled value.
  - Count freezing after 1 retry → `rsp_valid` at edge 6, `rsp_unstable`=0.
- Backpressure: `rsp_ready` held 0 for 10 cycles → `rsp_valid`/`rsp_data` stable, `req_ready`=0, new `req_valid` ignored; takes effect after the handshake.
- Reset mid-CLEAR: `reset_n` pulsed low → `odo_clear`=all ones during reset, `rsp_valid`=0, next request works normally.
- `ODO_DELTA_EN`: channel 1 reads 100 then 250 (0xFFFF_FFF0 then 0x10 for the wrap case) → `rsp_data`=100, then 150; wrap case gives 0x20. `odo_clear` never asserts after reset.
